// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register: valid/ready handshake backed by a 2-entry skid buffer, with synchronous flush.
// Optional PIPE_SKID_STATS_EN adds stall_cnt / flush_cnt statistics outputs.
module pipe_skid_reg #(
    parameter int unsigned       DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_main;
    logic [DATA_W-1:0]   r_skid;
    logic                w_in_fire;
    logic                w_out_fire;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

    // Handshake flags are registered next to the state so in_ready never sees out_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= FLUSH_VAL;
            r_skid      <= FLUSH_VAL;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= FLUSH_VAL;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_state     <= ST_BUSY;
                        r_out_valid <= 1'b1;
                        r_main      <= in_data;
                    end
                end
                ST_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= in_data;
                    end else if (w_in_fire) begin
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b0;
                        r_skid     <= in_data;
                    end else if (w_out_fire) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                        r_main      <= FLUSH_VAL;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        r_state    <= ST_BUSY;
                        r_in_ready <= 1'b1;
                        r_main     <= r_skid;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_main      <= FLUSH_VAL;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Free-running event counters; only rst clears them, they wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (r_out_valid && !out_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush && (r_state != ST_EMPTY)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed stimulus pushes expected beats, a negedge monitor pops on out_fire.
module tb_pipe_skid_reg;

    localparam int unsigned       DW    = 32;
    localparam logic [DW-1:0]     FV    = 32'h0BAD_F00D;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
`ifdef PIPE_SKID_STATS_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   flush_cnt;
`endif

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] sb[$];

    pipe_skid_reg #(.DATA_W(DW), .FLUSH_VAL(FV)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every out_fire must match the oldest expected beat; bubbles must carry FLUSH_VAL.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got %h expected none", out_data);
                    end else begin
                        chk("out_data", 32'(out_data), 32'(sb.pop_front()));
                    end
                end else if (!out_valid) begin
                    chk("bubble_data", 32'(out_data), 32'(FV));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  32'(out_data),  32'(FV));
        tick();
        chk("rst_nothing_captured", 32'(out_valid), 32'd0);

        // Streaming 1..8 at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            sb.push_back(32'(i));
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
            if (i == 1) chk("stream_latency", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure: A, B fill the buffer, C waits upstream
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; sb.push_back(32'hA);
        tick();
        in_data = 32'hB; sb.push_back(32'hB);
        tick();
        in_data = 32'hC;
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_data",     32'(out_data), 32'hA);
        out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        sb.push_back(32'hC);
        tick();
        in_valid = 1'b0;
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Flush from FULL; 0x11/0x22 dropped, 0x33 never accepted
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        chk("fl_full_data",     32'(out_data), 32'h11);
        chk("fl_full_in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1; in_data = 32'h33;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_out_data",  32'(out_data),  32'(FV));
        chk("fl_in_ready",  32'(in_ready),  32'd1);
        out_ready = 1'b1;
        tick();
        tick();
        chk("fl_no_beats", 32'(out_valid), 32'd0);

        // Reset mid-transfer in FULL with out_ready high
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h66;
        tick();
        in_data = 32'h77;
        tick();
        chk("rm_full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_out_valid", 32'(out_valid), 32'd0);
        chk("rm_in_ready",  32'(in_ready),  32'd1);
        chk("rm_out_data",  32'(out_data),  32'(FV));
        tick();
        tick();
        chk("rm_no_beats", 32'(out_valid), 32'd0);
`ifdef PIPE_SKID_STATS_EN
        chk("rm_stall_cnt", stall_cnt, 32'd0);
        chk("rm_flush_cnt", flush_cnt, 32'd0);
`endif

        // Stall for 5 cycles in BUSY, then flush while delivering; incoming 0x55 is consumed and dropped
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h88;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("st_hold_data", 32'(out_data), 32'h88);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h55;
        sb.push_back(32'h88);
        chk("st_flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("st_out_valid", 32'(out_valid), 32'd0);
`ifdef PIPE_SKID_STATS_EN
        chk("st_stall_cnt", stall_cnt, 32'd5);
        chk("st_flush_cnt", flush_cnt, 32'd1);
`endif
        tick();
        tick();
        chk("st_no_beats", 32'(out_valid), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised elastic pipeline register between any two stages of the MIPS pipeline (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It replaces freeze-style stage registers with a valid/ready handshake backed by a 2-entry skid buffer, so backpressure never creates a combinational ready path. It runs at full throughput, carries a generic payload (for example, PC and instruction concatenated), and supports a synchronous flush that turns the stage into a bubble.

Parameters:
DATA_W, 64, payload width in bits (e.g. {PC[31:0], instruction[31:0]}).
FLUSH_VAL, {DATA_W{1'b0}}, value driven on out_data whenever out_valid=0 (the bubble/NOP encoding).

Ports:
clk  input  1  clock, all state updates on posedge.
rst  input  1  synchronous, active-high reset.
flush  input  1  discard all held and incoming beats this cycle.
in_valid  input  1  upstream has a beat on in_data.
in_ready  output  1  block can accept a beat; registered, depends only on internal state.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  out_data holds a valid beat.
out_ready  input  1  downstream accepts out_data this cycle.
out_data  output  DATA_W  payload to downstream; equals FLUSH_VAL when out_valid=0.

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. A beat transfers only on a fire.
- Storage: main register (drives out_data) and skid register. Both are DATA_W wide.
- States: EMPTY (0 beats), BUSY (1 beat, in main), FULL (2 beats, main older, skid newer).
- Outputs per state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
- Transitions, when flush=0:
  - EMPTY: in_fire -> BUSY, main<=in_data.
  - BUSY:
    - in_fire & out_fire -> BUSY, main<=in_data.
    - in_fire & !out_fire -> FULL, skid<=in_data.
    - !in_fire & out_fire -> EMPTY, main<=FLUSH_VAL.
    - otherwise hold.
  - FULL: out_fire -> BUSY, main<=skid. Otherwise hold. in_fire is impossible because in_ready=0.
- Latency and throughput: a beat accepted at edge N appears on out_data after edge N (1 cycle) when the block was EMPTY or BUSY with out_fire. Sustained throughput is 1 beat/cycle with out_ready held high.
- Ordering: strictly FIFO. No beat is duplicated or dropped except by flush.
- Flush:
  - At the next edge, state<=EMPTY and main<=FLUSH_VAL. Skid contents are don't-care.
  - A beat presented with in_valid & in_ready in the flush cycle is consumed and dropped. An out_fire in the flush cycle still counts as delivered.
- Reset:
  - Synchronous. At a posedge with rst=1: state=EMPTY, out_valid=0, in_ready=1 (after the edge), out_data=FLUSH_VAL, skid=FLUSH_VAL.
  - rst has priority over flush and over all handshakes, including reset mid-transfer in FULL state.
- X-safety: in_data is not sampled unless in_fire. out_ready is ignored while out_valid=0.

Optional Feature:
PIPE_SKID_STATS_EN.
- Defined:
  - Adds output ports stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments every cycle with out_valid & !out_ready.
  - flush_cnt increments every cycle with flush=1 while state != EMPTY.
  - Both counters wrap at 2^32-1 -> 0, clear on rst, and are unaffected by flush.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, in_data=0xDEAD -> out_valid=0, out_data=FLUSH_VAL, in_ready=1 after release; nothing was captured.
- Streaming: in_valid=1 for 8 cycles with data 1..8 and out_ready=1 -> out_data=1..8 on consecutive cycles starting 1 cycle after the first accept; in_ready stays 1 throughout.
- Backpressure: stream 0xA, 0xB, 0xC with out_ready=0 -> after 0xA and 0xB are accepted, in_ready=0 and 0xC is held upstream. Raise out_ready -> output order is 0xA, 0xB, 0xC with no loss.
- Flush: in FULL state (0x11 in main, 0x22 in skid), pulse flush with in_valid=1, in_data=0x33 -> next cycle out_valid=0, out_data=FLUSH_VAL, state EMPTY; 0x33 never appears.
- Reset mid-operation: assert rst in FULL state with out_ready=1 -> next cycle EMPTY, no further beats emitted.
- Stats: with PIPE_SKID_STATS_EN defined, hold out_ready=0 for 5 cycles with out_valid=1, then flush once in BUSY -> stall_cnt=5, flush_cnt=1.
